// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Owns a double-buffered video memory (2 banks x 2^ADDR_W bytes)
//             held in one single-port synchronous RAM. The VGA scanout reader
//             reads the front bank and always wins the port; the GPU writer
//             fills the back bank through a valid/ready handshake. Front/back
//             swaps are sequenced at frame end, optionally followed by a clear
//             of the new back bank.
//  Ports    : clock_i, reset_i         - clock, synchronous active-high reset
//             vga_rd_i, vga_addr_i     - scanout read request / address
//             vga_data_o               - read data (RAM read port pass-through)
//             vga_data_valid_o         - vga_data_o answers last cycle's read
//             end_frame_i              - end-of-visible-frame pulse
//             gpu_valid_i/gpu_ready_o  - GPU write handshake
//             gpu_addr_i, gpu_wdata_i  - GPU write address / data
//             swap_req_i, swap_ack_o   - swap request level / done pulse
//             front_bank_o             - bank currently scanned out
//             clear_busy_o             - back-bank clear in progress
//             mem_addr_o, mem_we_o,
//             mem_wdata_o, mem_rdata_i - single-port RAM interface
//  Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int                ADDR_W        = 12,
  parameter int                DATA_W        = 8,
  parameter int                CLEAR_ON_SWAP = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = '0
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              vga_rd_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic [DATA_W-1:0] vga_data_o,
  output logic              vga_data_valid_o,
  input  logic              end_frame_i,
  input  logic              gpu_valid_i,
  output logic              gpu_ready_o,
  input  logic [ADDR_W-1:0] gpu_addr_i,
  input  logic [DATA_W-1:0] gpu_wdata_i,
  input  logic              swap_req_i,
  output logic              swap_ack_o,
  output logic              front_bank_o,
  output logic              clear_busy_o,
  output logic [ADDR_W:0]   mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_SWAP_PEND = 2'd1;
  localparam logic [1:0] S_CLEAR     = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              front_bank_q, front_bank_d;
  logic              swap_ack_q, swap_ack_d;
  logic              vga_valid_q;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              gpu_ready;

  // State register together with the bank/ack/clear-counter registers.
  // Reset drops everything, so an interrupted swap or clear is simply abandoned.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      front_bank_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      vga_valid_q  <= 1'b0;
      clr_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_bank_q <= front_bank_d;
      swap_ack_q   <= swap_ack_d;
      vga_valid_q  <= vga_rd_i;
      clr_cnt_q    <= clr_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    front_bank_d = front_bank_q;
    swap_ack_d   = 1'b0;
    clr_cnt_d    = clr_cnt_q;
    case (state_q)
      // end_frame is not looked at here: a swap first seen together with
      // end_frame waits for the following frame end.
      S_IDLE: begin
        if (swap_req_i) begin
          state_d = S_SWAP_PEND;
        end
      end
      S_SWAP_PEND: begin
        if (end_frame_i) begin
          front_bank_d = ~front_bank_q;
          swap_ack_d   = 1'b1;
          state_d      = (CLEAR_ON_SWAP != 0) ? S_CLEAR : S_IDLE;
        end
      end
      S_CLEAR: begin
        // Scanout owns the port on vga_rd cycles, so the clear only
        // advances when the port is free. The counter wraps back to 0 on
        // the final byte, leaving it ready for the next clear.
        if (!vga_rd_i) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs and RAM port mux. Reset gates every write source so nothing is
  // written while the state is being forced back to IDLE.
  always_comb begin
    gpu_ready   = ~reset_i & ~vga_rd_i & (state_q == S_IDLE);
    mem_addr_o  = {front_bank_q, vga_addr_i};
    mem_we_o    = 1'b0;
    mem_wdata_o = gpu_wdata_i;
    if (!vga_rd_i && !reset_i) begin
      if (state_q == S_CLEAR) begin
        mem_addr_o  = {~front_bank_q, clr_cnt_q};
        mem_we_o    = 1'b1;
        mem_wdata_o = CLEAR_VALUE;
      end else if (gpu_valid_i && gpu_ready) begin
        mem_addr_o  = {~front_bank_q, gpu_addr_i};
        mem_we_o    = 1'b1;
        mem_wdata_o = gpu_wdata_i;
      end
    end
  end

  assign gpu_ready_o      = gpu_ready;
  assign clear_busy_o     = ~reset_i & (state_q == S_CLEAR);
  assign swap_ack_o       = swap_ack_q;
  assign front_bank_o     = front_bank_q;
  assign vga_data_valid_o = vga_valid_q;
  assign vga_data_o       = mem_rdata_i;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_vram_arbiter
//  Purpose  : Self-checking bench for vram_arbiter. A clearing instance and a
//             non-clearing instance share the stimulus; the clearing one is
//             attached to a behavioural 8 KiB RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  logic        clock = 1'b0;
  logic        reset, vga_rd, end_frame, gpu_valid, swap_req;
  logic [11:0] vga_addr, gpu_addr;
  logic [7:0]  gpu_wdata, mem_rdata;
  logic [7:0]  vga_data, mem_wdata;
  logic        vga_data_valid, gpu_ready, swap_ack, front_bank, clear_busy, mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  n_vga_data, n_mem_wdata, n_mem_rdata;
  logic        n_vga_data_valid, n_gpu_ready, n_swap_ack, n_front_bank, n_clear_busy, n_mem_we;
  logic [12:0] n_mem_addr;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram [8192];
  int         wr_cnt [8192];
  int         wr_total = 0;
  int         wr_snap [8192];
  logic [7:0] exp_bank1 [4096];
  logic       prefill_en;

  assign n_mem_rdata = 8'h00;

  always #5 clock = ~clock;

  vram_arbiter #(.CLEAR_ON_SWAP(1)) u_dut (
    .clock_i(clock), .reset_i(reset), .vga_rd_i(vga_rd), .vga_addr_i(vga_addr),
    .vga_data_o(vga_data), .vga_data_valid_o(vga_data_valid), .end_frame_i(end_frame),
    .gpu_valid_i(gpu_valid), .gpu_ready_o(gpu_ready), .gpu_addr_i(gpu_addr),
    .gpu_wdata_i(gpu_wdata), .swap_req_i(swap_req), .swap_ack_o(swap_ack),
    .front_bank_o(front_bank), .clear_busy_o(clear_busy), .mem_addr_o(mem_addr),
    .mem_we_o(mem_we), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  vram_arbiter #(.CLEAR_ON_SWAP(0)) u_dut_nc (
    .clock_i(clock), .reset_i(reset), .vga_rd_i(vga_rd), .vga_addr_i(vga_addr),
    .vga_data_o(n_vga_data), .vga_data_valid_o(n_vga_data_valid), .end_frame_i(end_frame),
    .gpu_valid_i(gpu_valid), .gpu_ready_o(n_gpu_ready), .gpu_addr_i(gpu_addr),
    .gpu_wdata_i(gpu_wdata), .swap_req_i(swap_req), .swap_ack_o(n_swap_ack),
    .front_bank_o(n_front_bank), .clear_busy_o(n_clear_busy), .mem_addr_o(n_mem_addr),
    .mem_we_o(n_mem_we), .mem_wdata_o(n_mem_wdata), .mem_rdata_i(n_mem_rdata)
  );

  // Behavioural RAM: synchronous write, registered read. Prefilled with
  // ram[a] = a[7:0] while the initial reset is held.
  always @(posedge clock) begin
    if (reset && prefill_en) begin
      for (int i = 0; i < 8192; i++) begin
        ram[i]    <= 8'(i);
        wr_cnt[i] <= 0;
      end
    end else begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
        wr_total         <= wr_total + 1;
      end
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; prefill_en = 1'b1; vga_rd = 1'b0; vga_addr = '0; end_frame = 1'b0;
    gpu_valid = 1'b1; gpu_addr = 12'h321; gpu_wdata = 8'h99; swap_req = 1'b0;
    repeat (3) step();
    #1;
    tests++;
    if ({gpu_ready, mem_we, front_bank, swap_ack, clear_busy, vga_data_valid, n_gpu_ready, n_mem_we} !== 8'b0) begin
      fails++;
      $display("FAIL reset_during: rdy=%b we=%b fb=%b ack=%b busy=%b vv=%b nrdy=%b nwe=%b required all 0",
               gpu_ready, mem_we, front_bank, swap_ack, clear_busy, vga_data_valid, n_gpu_ready, n_mem_we);
    end
    // first cycle after reset: issue the first scanout read
    reset = 1'b0; prefill_en = 1'b0; gpu_valid = 1'b0; vga_rd = 1'b1; vga_addr = 12'h010;
    #1;
    tests++;
    if ({gpu_ready, mem_we, front_bank, swap_ack, clear_busy, vga_data_valid} !== 6'b0) begin
      fails++;
      $display("FAIL reset_after: rdy=%b we=%b fb=%b ack=%b busy=%b vv=%b required all 0",
               gpu_ready, mem_we, front_bank, swap_ack, clear_busy, vga_data_valid);
    end
    tests++;
    if (mem_addr !== 13'h0010) begin
      fails++;
      $display("FAIL first_read_addr: mem_addr=%h required 0010", mem_addr);
    end
    step();
    tests++;
    if (vga_data_valid !== 1'b1 || vga_data !== 8'h10) begin
      fails++;
      $display("FAIL first_read_data: valid=%b data=%h required 1/10", vga_data_valid, vga_data);
    end
  endtask

  task automatic test_random_reads();
    logic        prev_rd;
    logic [11:0] prev_addr;
    for (int i = 0; i < 40; i++) begin
      prev_rd = vga_rd; prev_addr = vga_addr;
      step();
      vga_rd   = 1'($urandom_range(0, 1));
      vga_addr = 12'($urandom);
      #1;
      tests++;
      if (vga_data_valid !== prev_rd) begin
        fails++;
        $display("FAIL rd_valid[%0d]: valid=%b required %b", i, vga_data_valid, prev_rd);
      end
      // bank 0 still holds its prefill pattern
      if (prev_rd) begin
        tests++;
        if (vga_data !== prev_addr[7:0]) begin
          fails++;
          $display("FAIL rd_data[%0d]: data=%h required %h", i, vga_data, prev_addr[7:0]);
        end
      end
      if (vga_rd) begin
        tests++;
        if (mem_addr !== {1'b0, vga_addr} || mem_we !== 1'b0) begin
          fails++;
          $display("FAIL rd_addr[%0d]: addr=%h we=%b required %h/0", i, mem_addr, mem_we, {1'b0, vga_addr});
        end
      end
    end
  endtask

  task automatic test_gpu_vs_vga();
    int  base;
    logic exp_rdy;
    logic hs;
    step();
    base = wr_cnt[13'h10FF];
    gpu_valid = 1'b1; gpu_addr = 12'h0FF; gpu_wdata = 8'hAB;
    for (int i = 0; i < 8; i++) begin
      vga_rd = (i % 2 == 0);
      vga_addr = 12'(i * 7);
      #1;
      exp_rdy = !vga_rd;
      hs = gpu_valid && exp_rdy;
      if (gpu_valid) begin
        tests++;
        if (gpu_ready !== exp_rdy) begin
          fails++;
          $display("FAIL toggle_ready[%0d]: ready=%b required %b", i, gpu_ready, exp_rdy);
        end
      end
      if (hs) begin
        tests++;
        if (mem_addr !== 13'h10FF || mem_we !== 1'b1 || mem_wdata !== 8'hAB) begin
          fails++;
          $display("FAIL toggle_write: addr=%h we=%b data=%h required 10FF/1/AB", mem_addr, mem_we, mem_wdata);
        end
      end
      step();
      if (hs) gpu_valid = 1'b0;
    end
    tests++;
    if (wr_cnt[13'h10FF] - base !== 1 || ram[13'h10FF] !== 8'hAB) begin
      fails++;
      $display("FAIL toggle_once: writes=%0d data=%h required 1/AB", wr_cnt[13'h10FF] - base, ram[13'h10FF]);
    end
  endtask

  task automatic test_random_writes();
    int   bad;
    logic exp_rdy;
    for (int i = 0; i < 4096; i++) exp_bank1[i] = 8'(i);
    exp_bank1[12'h0FF] = 8'hAB;
    for (int i = 0; i < 300; i++) begin
      vga_rd    = ($urandom_range(0, 2) == 0);
      vga_addr  = 12'($urandom);
      gpu_valid = 1'($urandom_range(0, 1));
      gpu_addr  = 12'($urandom);
      gpu_wdata = 8'($urandom);
      #1;
      exp_rdy = !vga_rd;
      tests++;
      if (gpu_ready !== exp_rdy) begin
        fails++;
        $display("FAIL rand_ready[%0d]: ready=%b required %b", i, gpu_ready, exp_rdy);
      end
      if (gpu_valid && exp_rdy) exp_bank1[gpu_addr] = gpu_wdata;
      step();
    end
    gpu_valid = 1'b0; vga_rd = 1'b0;
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (ram[4096 + i] !== exp_bank1[i]) bad++;
      if (ram[i] !== 8'(i)) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rand_mem: %0d bytes differ, required 0", bad);
    end
  endtask

  task automatic test_swap();
    int base_total, bad_rdy;
    // swap request cycle: a write handshaken now still lands in bank 1
    swap_req = 1'b1; vga_rd = 1'b0; gpu_valid = 1'b1; gpu_addr = 12'h123; gpu_wdata = 8'h5A;
    base_total = wr_total;
    #1;
    tests++;
    if (gpu_ready !== 1'b1 || mem_addr !== 13'h1123 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL swap_req_write: rdy=%b addr=%h we=%b required 1/1123/1", gpu_ready, mem_addr, mem_we);
    end
    step();
    bad_rdy = 0;
    for (int i = 0; i < 100; i++) begin
      gpu_addr = 12'($urandom); vga_rd = 1'($urandom_range(0, 1));
      #1;
      if (gpu_ready !== 1'b0 || n_gpu_ready !== 1'b0 || front_bank !== 1'b0 || swap_ack !== 1'b0) bad_rdy++;
      step();
    end
    tests++;
    if (bad_rdy != 0 || wr_total - base_total != 1 || ram[13'h1123] !== 8'h5A) begin
      fails++;
      $display("FAIL swap_pend: bad_cycles=%0d writes=%0d data=%h required 0/1/5A",
               bad_rdy, wr_total - base_total, ram[13'h1123]);
    end
    gpu_valid = 1'b0; vga_rd = 1'b0; end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    #1;
    tests++;
    if ({front_bank, swap_ack, clear_busy} !== 3'b111 || {n_front_bank, n_swap_ack, n_clear_busy} !== 3'b110) begin
      fails++;
      $display("FAIL swap_edge: fb/ack/busy=%b%b%b nc=%b%b%b required 111/110",
               front_bank, swap_ack, clear_busy, n_front_bank, n_swap_ack, n_clear_busy);
    end
    tests++;
    if (n_gpu_ready !== 1'b1 || gpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL swap_ready: nc_ready=%b clr_ready=%b required 1/0", n_gpu_ready, gpu_ready);
    end
    swap_req = 1'b0;
  endtask

  // Starts in the swap_ack cycle; scanout reads on alternate cycles,
  // beginning with a read, so the clear advances every other cycle.
  task automatic test_clear();
    int busy_len, exp_len, writes, bad_rdy, bad, base_total;
    writes = 0; exp_len = 0;
    while (writes < 4096) begin
      if (exp_len % 2 == 1) writes++;
      exp_len++;
    end
    for (int i = 0; i < 8192; i++) wr_snap[i] = wr_cnt[i];
    base_total = wr_total;
    gpu_valid = 1'b1; gpu_addr = 12'h777; gpu_wdata = 8'hEE;
    busy_len = 0; bad_rdy = 0;
    while (clear_busy === 1'b1 && busy_len < 20000) begin
      vga_rd = (busy_len % 2 == 0);
      vga_addr = 12'(busy_len);
      #1;
      if (gpu_ready !== 1'b0) bad_rdy++;
      if (busy_len == 1) begin
        tests++;
        if (swap_ack !== 1'b0 || n_swap_ack !== 1'b0) begin
          fails++;
          $display("FAIL ack_width: ack=%b nc_ack=%b required 0/0", swap_ack, n_swap_ack);
        end
      end
      step();
      busy_len++;
    end
    tests++;
    if (busy_len != exp_len || bad_rdy != 0) begin
      fails++;
      $display("FAIL clear_len: busy=%0d ready_viol=%0d required %0d/0", busy_len, bad_rdy, exp_len);
    end
    bad = 0;
    for (int i = 0; i < 4096; i++) begin
      if (wr_cnt[i] - wr_snap[i] != 1 || ram[i] !== 8'h00) bad++;
    end
    tests++;
    if (bad != 0 || wr_total - base_total != 4096) begin
      fails++;
      $display("FAIL clear_bank0: bad_addrs=%0d writes=%0d required 0/4096", bad, wr_total - base_total);
    end
    vga_rd = 1'b0;
    #1;
    tests++;
    if (gpu_ready !== 1'b1 || mem_addr !== 13'h0777 || mem_we !== 1'b1) begin
      fails++;
      $display("FAIL clear_exit_ready: rdy=%b addr=%h we=%b required 1/0777/1", gpu_ready, mem_addr, mem_we);
    end
    step();
    gpu_valid = 1'b0;
  endtask

  task automatic test_same_cycle_swap();
    swap_req = 1'b1; end_frame = 1'b1; vga_rd = 1'b0;
    step();
    end_frame = 1'b0;
    #1;
    tests++;
    if (front_bank !== 1'b1 || n_front_bank !== 1'b1 || swap_ack !== 1'b0 || gpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL same_cycle: fb=%b nfb=%b ack=%b rdy=%b required 1/1/0/0",
               front_bank, n_front_bank, swap_ack, gpu_ready);
    end
    repeat (5) step();
    end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    #1;
    tests++;
    if (front_bank !== 1'b0 || n_front_bank !== 1'b0 || swap_ack !== 1'b1) begin
      fails++;
      $display("FAIL next_frame_swap: fb=%b nfb=%b ack=%b required 0/0/1", front_bank, n_front_bank, swap_ack);
    end
    swap_req = 1'b0;
  endtask

  // Starts in the swap_ack cycle with bank 1 as the new back bank; with no
  // scanout reads the clear counter reaches 0x200 after 512 cycles.
  task automatic test_reset_mid_clear();
    int bad;
    vga_rd = 1'b0; gpu_valid = 1'b0;
    repeat (512) step();
    tests++;
    if (mem_addr !== 13'h1200 || mem_we !== 1'b1 || clear_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_pos: addr=%h we=%b busy=%b required 1200/1/1", mem_addr, mem_we, clear_busy);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (mem_we !== 1'b0 || clear_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_clear_in_reset: we=%b busy=%b required 0/0", mem_we, clear_busy);
    end
    step();
    reset = 1'b0;
    #1;
    tests++;
    if ({clear_busy, front_bank, mem_we, swap_ack} !== 4'b0 || gpu_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_clear_abort: busy=%b fb=%b we=%b ack=%b rdy=%b required 0/0/0/0/1",
               clear_busy, front_bank, mem_we, swap_ack, gpu_ready);
    end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (swap_ack !== 1'b0 || clear_busy !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_clear_quiet: %0d bad cycles, required 0", bad);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_random_reads();
    test_gpu_vs_vga();
    test_random_writes();
    test_swap();
    test_clear();
    test_same_cycle_swap();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
